// File: rtl/shift_pkg.sv
// shift_pkg: shared state encoding and default sizes for the iterative right shifter.
package shift_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;
    localparam int WIDTH_DEF = 32;
    localparam int SHAMT_W_DEF = 5;
    localparam int FAST_STEP = 4;
endpackage

// File: rtl/shift_right_step.sv
// shift_right_step: one combinational right-shift step of 1 or 4 positions with a given fill bit.
module shift_right_step
    import shift_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] value,
    input  logic             fill,
    input  logic             step4,
    output logic [WIDTH-1:0] shifted
);
    always_comb shifted = step4 ? {{FAST_STEP{fill}}, value[WIDTH-1:FAST_STEP]} : {fill, value[WIDTH-1:1]};
endmodule

// File: rtl/shift_right_seq.sv
// shift_right_seq: multi-cycle logical/arithmetic right shifter with start/busy/done handshake.
// Define SHIFT_RIGHT_SEQ_FAST4_EN to take 4-bit steps while at least 4 positions remain.
module shift_right_seq
    import shift_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SHAMT_W = SHAMT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               arith,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   y
);
    state_t             state, state_nx;
    logic [WIDTH-1:0]   sreg, shifted;
    logic [SHAMT_W-1:0] count, step_amt;
    logic               fill, step4, last;

`ifdef SHIFT_RIGHT_SEQ_FAST4_EN
    assign step4 = count >= SHAMT_W'(FAST_STEP);
`else
    assign step4 = 1'b0;
`endif
    assign step_amt = step4 ? SHAMT_W'(FAST_STEP) : SHAMT_W'(1);
    assign last = count == step_amt;

    shift_right_step #(.WIDTH(WIDTH)) u_step (
        .value(sreg),
        .fill(fill),
        .step4(step4),
        .shifted(shifted)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nx;

    always_comb
        state_nx = state == IDLE  ? (start ? (shamt == '0 ? FIN : SHIFT) : IDLE) :
                   state == SHIFT ? (last ? FIN : SHIFT) : IDLE;

    always_comb begin
        busy = state == SHIFT;
        done = state == FIN;
    end

    // y is loaded on the edge entering FIN so it is already valid while done is high
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            sreg  <= '0;
            count <= '0;
            fill  <= 1'b0;
            y     <= '0;
        end else if (state == IDLE && start) begin
            sreg  <= a;
            count <= shamt;
            fill  <= arith & a[WIDTH-1];
            if (shamt == '0) y <= a;
        end else if (state == SHIFT) begin
            sreg  <= shifted;
            count <= count - step_amt;
            if (last) y <= shifted;
        end
endmodule

// File: tb/tb_shift_right_seq.sv
// tb_shift_right_seq: scoreboard bench for shift_right_seq (follows SHIFT_RIGHT_SEQ_FAST4_EN when defined).
module tb_shift_right_seq;
    localparam int W = 32;
    localparam int S = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         arith = 1'b0;
    logic [W-1:0] a = '0;
    logic [S-1:0] shamt = '0;
    logic         busy, done;
    logic [W-1:0] y;

    int checks = 0;
    int failures = 0;
    logic [W-1:0] exp_y_q[$];
    int           exp_lat_q[$];

    always #5 clk = ~clk;

    shift_right_seq #(.WIDTH(W), .SHAMT_W(S)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .a(a),
        .shamt(shamt),
        .arith(arith),
        .busy(busy),
        .done(done),
        .y(y)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int model_lat(input int s);
`ifdef SHIFT_RIGHT_SEQ_FAST4_EN
        return s / 4 + s % 4 + 1;
`else
        return s + 1;
`endif
    endfunction

    task automatic run_op(input logic [W-1:0] op_a, input int op_s, input logic op_ar, input bit disturb);
        int lat, busy_n, el;
        logic [W-1:0] y_hold, ey;
        logic signed [W-1:0] sa;
        sa = op_a;
        @(negedge clk);
        a = op_a;
        shamt = S'(op_s);
        arith = op_ar;
        start = 1'b1;
        if (op_ar) ey = sa >>> op_s;
        else ey = op_a >> op_s;
        exp_y_q.push_back(ey);
        exp_lat_q.push_back(model_lat(op_s));
        y_hold = y;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        busy_n = 0;
        while (!done && lat < 100) begin
            if (busy) busy_n++;
            check("y_stable_in_shift", y, y_hold);
            if (disturb && lat == 2) begin
                a = 32'h1234_5678;
                shamt = S'(1);
                arith = ~op_ar;
                start = 1'b1;
            end else start = 1'b0;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        ey = exp_y_q.pop_front();
        el = exp_lat_q.pop_front();
        check("done", 32'(done), 32'd1);
        check("y", y, ey);
        check("latency", 32'(lat), 32'(el));
        check("busy_cycles", 32'(busy_n), 32'(el - 1));
        check("busy_at_done", 32'(busy), 32'd0);
        if (disturb) begin
            a = 32'h1234_5678;
            shamt = S'(3);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (3) begin
                check("ignored_done", 32'(done), 32'd0);
                check("ignored_busy", 32'(busy), 32'd0);
                check("y_held", y, ey);
                @(negedge clk);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_y", y, 32'd0);
        rst = 1'b0;

        run_op(32'h8000_0000, 4, 1'b0, 1'b0);
        run_op(32'hF000_0000, 4, 1'b1, 1'b0);
        run_op(32'h7000_0000, 4, 1'b1, 1'b0);
        run_op(32'hDEAD_BEEF, 0, 1'b0, 1'b0);
        run_op(32'h8000_0001, 31, 1'b0, 1'b0);
        run_op(32'h8000_0001, 31, 1'b1, 1'b0);
        run_op(32'hC35A_0F0F, 7, 1'b1, 1'b0);
        run_op(32'hC000_0000, 6, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++)
            run_op(W'($urandom), int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'b0);
        run_op(32'h8765_4321, 9, 1'b0, 1'b1);

        // abort a long operation with an asynchronous reset between edges
        @(negedge clk);
        a = 32'hFFFF_FFFF;
        shamt = S'(20);
        arith = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("busy_before_abort", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_y", y, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("post_abort_done", 32'(done), 32'd0);
        end
        run_op(32'h0000_0010, 4, 1'b0, 1'b0);
        check("queue_empty", 32'(exp_y_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
